// File: rtl/key_capture_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_capture_controller_pkg
// Description : Shared types and defaults for the key capture controller:
//               FSM state encoding, line-counter width, parameter defaults
//               and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package key_capture_controller_pkg;

    // Capture FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        WAIT_VSYNC  = 2'd0,
        COUNT_LINES = 2'd1,
        CAPTURE     = 2'd2,
        EVALUATE    = 2'd3
    } capture_state_t;

    localparam int               c_line_w                 = 10;
    localparam logic [c_line_w-1:0] c_key_line_default    = 10'd21;
    localparam int               c_confirm_frames_default = 3;
    localparam int               c_miss_limit_default     = 8;

    // Bits needed to hold 0..max_val, never narrower than min_w
    function automatic int cnt_width(input int max_val, input int min_w);
        int w;
        w = $clog2(max_val + 1);
        return (w < min_w) ? min_w : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_handshake_buffer.sv
`default_nettype none
// ============================================================================
// Module      : key_handshake_buffer
// Description : Output stage for confirmed keys. Holds the offered key in an
//               output register with valid/ready handshake and buffers one
//               further key while a transfer is pending (latest wins).
//               Keys equal to the last delivered key are not re-offered.
// Ports       : clock, reset_n      - clock, async active-low reset
//               offer, offer_key    - one-cycle request to present a key
//               key_ready           - consumer accepts key_out
//               key_out, key_valid  - presented key and its valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module key_handshake_buffer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        offer,
    input  logic [31:0] offer_key,
    input  logic        key_ready,
    output logic [31:0] key_out,
    output logic        key_valid
);

    logic [31:0] r_key_out;
    logic        r_key_valid;
    logic [31:0] r_hold;
    logic        r_hold_valid;
    logic [31:0] r_last_key;
    logic        r_last_valid;

    logic w_xfer;
    logic w_accept;

    assign w_xfer   = r_key_valid & key_ready;
    // A key already handed to the consumer is not offered a second time
    assign w_accept = offer & ~(r_last_valid & (offer_key == r_last_key));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_out    <= 32'h0;
            r_key_valid  <= 1'b0;
            r_hold       <= 32'h0;
            r_hold_valid <= 1'b0;
            r_last_key   <= 32'h0;
            r_last_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_last_key   <= r_key_out;
                r_last_valid <= 1'b1;
            end

            if (w_xfer) begin
                if (w_accept) begin
                    // Fresh key supersedes anything held; valid stays high
                    r_key_out    <= offer_key;
                    r_key_valid  <= 1'b1;
                    r_hold_valid <= 1'b0;
                end else if (r_hold_valid) begin
                    r_key_out    <= r_hold;
                    r_key_valid  <= 1'b1;
                    r_hold_valid <= 1'b0;
                end else begin
                    r_key_valid  <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_key_valid) begin
                    r_key_out   <= offer_key;
                    r_key_valid <= 1'b1;
                end else begin
                    // Output is stalled: park the key, overwriting older ones
                    r_hold       <= offer_key;
                    r_hold_valid <= 1'b1;
                end
            end
        end
    end

    assign key_out   = r_key_out;
    assign key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: rtl/key_capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : key_capture_controller
// Description : Captures a scrambling key carried on a fixed video line,
//               confirms it over several frames and delivers it through a
//               valid/ready handshake. Drops lock after repeated misses.
// Ports       : clock, reset_n          - pixel clock, async active-low reset
//               vsync, hsync, avid      - decoder timing levels
//               det_sequence, det_ready - sequence detector result
//               det_reset_n             - detector enable (key line window)
//               key_out, key_valid      - confirmed key handshake output
//               key_ready               - consumer ready
//               locked                  - a key is currently confirmed
// Revision    : 1.0 - initial release
// ============================================================================
module key_capture_controller
    import key_capture_controller_pkg::*;
#(
    parameter logic [c_line_w-1:0] KEY_LINE = c_key_line_default,
    parameter int CONFIRM_FRAMES = c_confirm_frames_default,
    parameter int MISS_LIMIT     = c_miss_limit_default
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        hsync,
    input  logic        avid,
    input  logic [31:0] det_sequence,
    input  logic        det_ready,
    output logic        det_reset_n,
    output logic [31:0] key_out,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        locked
);

    localparam int c_match_w = cnt_width(CONFIRM_FRAMES, 2);
    localparam int c_miss_w  = cnt_width(MISS_LIMIT, 1);
    localparam logic [c_match_w-1:0] c_confirm = c_match_w'(CONFIRM_FRAMES);
    localparam logic [c_miss_w-1:0]  c_miss    = c_miss_w'(MISS_LIMIT);

    capture_state_t      r_state;
    logic                r_vsync_q, r_vsync_d;
    logic                r_hsync_q, r_hsync_d;
    logic                r_avid_q,  r_avid_d;
    logic [c_line_w-1:0] r_line_cnt;
    logic [31:0]         r_candidate;
    logic [c_match_w-1:0] r_match_cnt;
    logic [c_miss_w-1:0]  r_miss_cnt;
    logic                r_locked;
    logic                r_det_reset_n;

    logic w_vs_rise, w_hs_rise, w_av_rise, w_av_fall;
    logic w_miss_drop, w_lock_set;

    // Edges come from the registered copies only
    assign w_vs_rise = r_vsync_q & ~r_vsync_d;
    assign w_hs_rise = r_hsync_q & ~r_hsync_d;
    assign w_av_rise = r_avid_q  & ~r_avid_d;
    assign w_av_fall = ~r_avid_q & r_avid_d;

    assign w_miss_drop = r_locked & (r_miss_cnt == c_miss);
    assign w_lock_set  = ~r_locked & (r_match_cnt == c_confirm);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= WAIT_VSYNC;
            r_vsync_q     <= 1'b0;
            r_vsync_d     <= 1'b0;
            r_hsync_q     <= 1'b0;
            r_hsync_d     <= 1'b0;
            r_avid_q      <= 1'b0;
            r_avid_d      <= 1'b0;
            r_line_cnt    <= '0;
            r_candidate   <= 32'h0;
            r_match_cnt   <= '0;
            r_miss_cnt    <= '0;
            r_locked      <= 1'b0;
            r_det_reset_n <= 1'b0;
        end else begin
            r_vsync_q <= vsync;
            r_vsync_d <= r_vsync_q;
            r_hsync_q <= hsync;
            r_hsync_d <= r_hsync_q;
            r_avid_q  <= avid;
            r_avid_d  <= r_avid_q;

            // Lock bookkeeping; an EVALUATE below overrides these writes
            if (w_miss_drop) begin
                r_locked    <= 1'b0;
                r_match_cnt <= '0;
            end else if (w_lock_set) begin
                r_locked <= 1'b1;
            end

            case (r_state)
                WAIT_VSYNC: begin
                    if (w_vs_rise) begin
                        r_state    <= COUNT_LINES;
                        r_line_cnt <= '0;
                    end
                end
                COUNT_LINES, CAPTURE: begin
                    if (w_vs_rise) begin
                        // Frame ended without a usable capture: restart it
                        r_state       <= COUNT_LINES;
                        r_line_cnt    <= '0;
                        r_det_reset_n <= 1'b0;
                        if (r_miss_cnt != c_miss)
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                    end else if (r_state == COUNT_LINES) begin
                        if (w_hs_rise && r_line_cnt != '1)
                            r_line_cnt <= r_line_cnt + 1'b1;
                        if (w_av_rise && r_line_cnt == KEY_LINE) begin
                            r_state       <= CAPTURE;
                            r_det_reset_n <= 1'b1;
                        end
                    end else if (w_av_fall) begin
                        r_state       <= EVALUATE;
                        r_det_reset_n <= 1'b0;
                    end
                end
                EVALUATE: begin
                    r_state <= WAIT_VSYNC;
                    if (det_ready) begin
                        r_miss_cnt <= '0;
                        if (det_sequence == r_candidate) begin
                            if (r_match_cnt != c_confirm)
                                r_match_cnt <= r_match_cnt + 1'b1;
                        end else begin
                            r_candidate <= det_sequence;
                            r_match_cnt <= c_match_w'(1);
                            r_locked    <= 1'b0;
                        end
                    end else if (r_miss_cnt != c_miss) begin
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                end
                default: r_state <= WAIT_VSYNC;
            endcase
        end
    end

    key_handshake_buffer u_handshake (
        .clock     (clock),
        .reset_n   (reset_n),
        .offer     (w_lock_set),
        .offer_key (r_candidate),
        .key_ready (key_ready),
        .key_out   (key_out),
        .key_valid (key_valid)
    );

    assign det_reset_n = r_det_reset_n;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_key_capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_capture_controller
// Description : Directed self-checking bench for key_capture_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_capture_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync = 1'b0, hsync = 1'b0, avid = 1'b0;
    logic [31:0] det_sequence = 32'h0;
    logic        det_ready = 1'b0;
    logic        det_reset_n;
    logic [31:0] key_out;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        locked;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] K_A = 32'hA5A5_1234;
    localparam logic [31:0] K_B = 32'h0000_BEEF;

    always #5 clock = ~clock;

    key_capture_controller dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .hsync        (hsync),
        .avid         (avid),
        .det_sequence (det_sequence),
        .det_ready    (det_ready),
        .det_reset_n  (det_reset_n),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .locked       (locked)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One video frame with the key on line 21.
    // mode: 0 normal, 1 vsync during capture, 2 reset during capture,
    //       3 key_ready pulse on the lock cycle, 4 no leading vsync
    task automatic run_frame(input logic rdy, input logic [31:0] seq, input int mode,
                             output logic mid_drst, output logic evt_drst,
                             output logic evt_locked);
        det_ready    = rdy;
        det_sequence = seq;
        evt_drst     = 1'b1;
        evt_locked   = 1'b1;
        if (mode != 4) begin
            vsync = 1'b1; cyc(2); vsync = 1'b0; cyc(2);
        end
        repeat (21) begin
            hsync = 1'b1; cyc(2); hsync = 1'b0; cyc(2);
        end
        cyc(2);
        avid = 1'b1;
        cyc(4);
        mid_drst = det_reset_n;
        if (mode == 1) begin
            vsync = 1'b1; cyc(2);
            evt_drst = det_reset_n;
            vsync = 1'b0; cyc(1);
        end else if (mode == 2) begin
            reset_n = 1'b0; #1;
            evt_drst   = det_reset_n;
            evt_locked = locked;
            cyc(2);
            reset_n = 1'b1; cyc(1);
        end
        cyc(2);
        avid = 1'b0;
        if (mode == 3) begin
            cyc(3); key_ready = 1'b1; cyc(1); key_ready = 1'b0; cyc(3);
        end else begin
            cyc(7);
        end
        if (mode == 0) evt_drst = det_reset_n;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cyc(3);
        vectors++; if (det_reset_n !== 1'b0) begin miscompares++; $display("FAIL reset_det_reset_n got %b want 0", det_reset_n); end
        vectors++; if (key_out !== 32'h0) begin miscompares++; $display("FAIL reset_key_out got %h want 00000000", key_out); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
        reset_n = 1'b1; cyc(2);
    endtask

    task automatic test_lock;
        logic m, e, l;
        for (int i = 1; i <= 3; i++) begin
            run_frame(1'b1, K_A, 0, m, e, l);
            vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL lock_det_window f%0d got %b want 1", i, m); end
            vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL lock_det_after f%0d got %b want 0", i, e); end
            vectors++; if (locked !== (i == 3)) begin miscompares++; $display("FAIL lock_locked f%0d got %b want %b", i, locked, i == 3); end
            vectors++; if (key_valid !== (i == 3)) begin miscompares++; $display("FAIL lock_valid f%0d got %b want %b", i, key_valid, i == 3); end
        end
        vectors++; if (key_out !== K_A) begin miscompares++; $display("FAIL lock_key_out got %h want %h", key_out, K_A); end
    endtask

    task automatic test_backpressure;
        logic m, e, l;
        for (int i = 1; i <= 5; i++) begin
            run_frame(1'b1, K_B, 0, m, e, l);
            vectors++; if (locked !== (i >= 3)) begin miscompares++; $display("FAIL bp_locked f%0d got %b want %b", i, locked, i >= 3); end
            vectors++; if (key_out !== K_A || key_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stall f%0d got %h/%b want %h/1", i, key_out, key_valid, K_A); end
        end
        key_ready = 1'b1; cyc(1); key_ready = 1'b0;
        vectors++; if (key_out !== K_B || key_valid !== 1'b1) begin miscompares++; $display("FAIL bp_next got %h/%b want %h/1", key_out, key_valid, K_B); end
        key_ready = 1'b1; cyc(1); key_ready = 1'b0;
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", key_valid); end
    endtask

    task automatic test_miss_unlock;
        logic m, e, l;
        for (int i = 1; i <= 8; i++) begin
            run_frame(1'b0, K_B, 0, m, e, l);
            vectors++; if (locked !== (i < 8)) begin miscompares++; $display("FAIL miss_locked f%0d got %b want %b", i, locked, i < 8); end
        end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL miss_key_valid got %b want 0", key_valid); end
    endtask

    task automatic test_abort;
        logic m, e, l;
        run_frame(1'b1, K_B, 0, m, e, l);
        vectors++; if (dut.r_miss_cnt !== 4'd0) begin miscompares++; $display("FAIL abort_pre_miss got %0d want 0", dut.r_miss_cnt); end
        run_frame(1'b1, K_B, 1, m, e, l);
        vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL abort_window got %b want 1", m); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL abort_det_low got %b want 0", e); end
        vectors++; if (dut.r_miss_cnt !== 4'd1) begin miscompares++; $display("FAIL abort_miss got %0d want 1", dut.r_miss_cnt); end
    endtask

    task automatic test_reset_mid_capture;
        logic m, e, l;
        // Re-lock to the already delivered key: no new offer
        for (int i = 1; i <= 3; i++) run_frame(1'b1, K_B, 0, m, e, l);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL relock_locked got %b want 1", locked); end
        vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL relock_no_reoffer got %b want 0", key_valid); end
        run_frame(1'b1, 32'h3, 2, m, e, l);
        vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL rst_window got %b want 1", m); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL rst_det_imm got %b want 0", e); end
        vectors++; if (l !== 1'b0) begin miscompares++; $display("FAIL rst_locked_imm got %b want 0", l); end
        run_frame(1'b1, 32'h3, 4, m, e, l);
        vectors++; if (m !== 1'b0) begin miscompares++; $display("FAIL rst_no_capture got %b want 0", m); end
        run_frame(1'b1, 32'h3, 0, m, e, l);
        vectors++; if (m !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_capture got %b want 1", m); end
    endtask

    task automatic test_alternating;
        logic m, e, l;
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, (i % 2 == 0) ? 32'h1 : 32'h2, 0, m, e, l);
            vectors++; if (locked !== 1'b0 || key_valid !== 1'b0) begin miscompares++; $display("FAIL alt f%0d got locked=%b valid=%b want 0/0", i, locked, key_valid); end
        end
    endtask

    task automatic test_back_to_back;
        logic m, e, l;
        logic [31:0] keys [4];
        keys = '{32'hC0C0_0001, 32'hD0D0_0002, 32'hE0E0_0003, 32'hF0F0_0004};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 3; i++) run_frame(1'b1, keys[k], 0, m, e, l);
        vectors++; if (key_out !== keys[0] || key_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_first got %h/%b want %h/1", key_out, key_valid, keys[0]); end
        key_ready = 1'b1; cyc(1); key_ready = 1'b0;
        vectors++; if (key_out !== keys[2] || key_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_latest got %h/%b want %h/1", key_out, key_valid, keys[2]); end
        run_frame(1'b1, keys[3], 0, m, e, l);
        run_frame(1'b1, keys[3], 0, m, e, l);
        run_frame(1'b1, keys[3], 3, m, e, l);
        vectors++; if (key_out !== keys[3] || key_valid !== 1'b1 || locked !== 1'b1) begin miscompares++; $display("FAIL b2b_same_cycle got %h/%b/%b want %h/1/1", key_out, key_valid, locked, keys[3]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lock();
        test_backpressure();
        test_miss_unlock();
        test_abort();
        test_reset_mid_capture();
        test_alternating();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_capture_controller.md
KEY_CAPTURE_CONTROLLER -- requirements
Module: key_capture_controller

Interface
REQ-001 Parameter KEY_LINE, default 10'd21: line index after the vsync rising edge that carries the scrambling key.
REQ-002 Parameter CONFIRM_FRAMES, default 3: consecutive identical captured keys needed to lock.
REQ-003 Parameter MISS_LIMIT, default 8: consecutive frames with no valid capture before lock is dropped.
REQ-004 clock  input  1: pixel clock, rising edge active.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 vsync  input  1: decoder vertical sync, high-active level.
REQ-007 hsync  input  1: decoder horizontal sync, high-active level.
REQ-008 avid  input  1: decoder active-video window, high during active samples.
REQ-009 det_sequence  input  32: key word from the sequence detector.
REQ-010 det_ready  input  1: detector ID-match flag.
REQ-011 det_reset_n  output  1: registered reset to the detector; high only during the key line's active window.
REQ-012 key_out  output  32: confirmed key.
REQ-013 key_valid  output  1: key_out holds a new confirmed key.
REQ-014 key_ready  input  1: consumer accepts key_out; a transfer occurs on any cycle with key_valid and key_ready both high.
REQ-015 locked  output  1: a key is currently confirmed.

Function
REQ-016 Edge detection is synchronous: vsync, hsync and avid are registered once, and rising/falling edges are derived from the registered values.
REQ-017 FSM states: WAIT_VSYNC, COUNT_LINES, CAPTURE, EVALUATE. Reset state is WAIT_VSYNC.
REQ-018 Transition WAIT_VSYNC->COUNT_LINES on a vsync rising edge; the 10-bit line counter clears to 0 at that edge.
REQ-019 COUNT_LINES: the line counter increments on each hsync rising edge, saturating at 10'h3FF.
REQ-020 COUNT_LINES->CAPTURE on an avid rising edge when line counter == KEY_LINE; det_reset_n goes high on the next cycle.
REQ-021 CAPTURE->EVALUATE on an avid falling edge; det_reset_n goes low on the next cycle.
REQ-022 EVALUATE lasts one cycle and samples det_ready and det_sequence, then transitions to WAIT_VSYNC.
REQ-023 A vsync rising edge in COUNT_LINES or CAPTURE aborts the frame: det_reset_n goes low, the FSM enters COUNT_LINES with the counter cleared, and the frame is counted as a miss.
REQ-024 EVALUATE with det_ready=1: if det_sequence equals the candidate register, the 2-bit-minimum match counter increments (saturating at CONFIRM_FRAMES). Otherwise the candidate is loaded with det_sequence and the match counter is set to 1. The miss counter clears in both cases.
REQ-025 EVALUATE with det_ready=0: the miss counter increments (saturating), and the candidate and match counter are unchanged.
REQ-026 locked sets in the cycle after the match counter reaches CONFIRM_FRAMES.
REQ-027 locked clears in the cycle after the miss counter reaches MISS_LIMIT, or when a mismatching candidate replaces the confirmed key. The match counter is then cleared.
REQ-028 On a new lock, or on a re-lock to a value different from the last delivered key, the key is offered through the output handshake. Re-confirming the same key does not re-offer it.
REQ-029 key_out and key_valid stay stable while key_valid=1 and key_ready=0.
REQ-030 A one-entry holding register buffers a key confirmed while a transfer is pending. The latest such key wins, and it is presented the cycle after the transfer.
REQ-031 If a transfer and a new confirmation occur in the same cycle, the new key goes to key_out on the next cycle with key_valid held high.

Reset
REQ-032 Reset drives det_reset_n=0, key_out=32'h0, key_valid=0 and locked=0, and clears all counters, the candidate register, the holding register and the FSM state.
REQ-033 Reset asserted mid-capture takes effect immediately and asynchronously; the first capture after release waits for a fresh vsync edge.

Structure
REQ-034 A shared package holds the FSM state encoding, the 10-bit line-counter width, and the KEY_LINE / CONFIRM_FRAMES / MISS_LIMIT defaults.
REQ-035 One sub-module, key_handshake_buffer, implements the output register, the holding register and the valid/ready logic (REQ-028 to REQ-031).

Verification
REQ-036 Bench: three frames, each with det_ready=1 and key 32'hA5A5_1234 on line 21 -> locked=1 and key_valid=1 after the third EVALUATE; key_out=32'hA5A5_1234.
REQ-037 Bench: key_ready held low for five frames while the key changes to 32'h0000_BEEF and is confirmed -> key_out stays 32'hA5A5_1234; after one key_ready pulse, the next cycle shows key_out=32'h0000_BEEF with key_valid=1.
REQ-038 Bench: locked, then eight frames with det_ready=0 -> locked falls after the eighth EVALUATE; key_valid is unaffected.
REQ-039 Bench: vsync edge injected during CAPTURE on line 21 -> det_reset_n low within two cycles, and the miss counter increments by one.
REQ-040 Bench: reset_n pulsed low mid-CAPTURE -> det_reset_n=0 and locked=0 immediately; no capture occurs until the next vsync.
REQ-041 Bench: alternating keys 1,2,1,2 -> locked never asserts and key_valid stays 0.
